// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pkg
// Description : Opcode encodings and width helpers shared by the MAC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_MAC  = 2'd1,
        OP_MAS  = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    // Accumulator holds a full product plus guard bits for repeated sums.
    function automatic int acc_width(input int data_w, input int guard);
        return 2 * data_w + guard;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_shift.sv
`default_nettype none
// ============================================================================
// Module      : sat_shift
// Description : Arithmetic right shift with optional signed saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_shift #(
    parameter int IN_W   = 36,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter bit SAT_EN = 1'b1
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data
);

    logic signed [IN_W-1:0] w_shifted;

    assign w_shifted = $signed(i_data) >>> SHIFT;

    generate
        if (SAT_EN) begin : g_sat
            localparam logic signed [IN_W-1:0] c_max =
                {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [IN_W-1:0] c_min =
                {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

            always_comb begin
                o_data = w_shifted[OUT_W-1:0];
                if (w_shifted > c_max) begin
                    o_data = {1'b0, {(OUT_W-1){1'b1}}};
                end else if (w_shifted < c_min) begin
                    o_data = {1'b1, {(OUT_W-1){1'b0}}};
                end
            end
        end else begin : g_trunc
            assign o_data = w_shifted[OUT_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mac_pipe
// Description : Three-stage pipelined signed multiply-accumulate engine with
//               valid/ready ports and a shifted, saturated result register.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_pipe
    import dsp_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int GUARD     = 4,
    parameter int OUT_SHIFT = 15,
    parameter bit SAT_EN    = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [1:0]                           op,
    input  logic [DATA_W-1:0]                    a,
    input  logic [DATA_W-1:0]                    b,
    input  logic                                 last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_W-1:0]                    out_data,
    output logic [acc_width(DATA_W, GUARD)-1:0]  out_acc,
    output logic                                 ovf
);

    localparam int ACC_W = acc_width(DATA_W, GUARD);

    logic                     w_stall;

    logic                     r_s1_valid;
    op_e                      r_s1_op;
    logic signed [DATA_W-1:0] r_s1_a;
    logic signed [DATA_W-1:0] r_s1_b;
    logic                     r_s1_last;

    logic signed [2*DATA_W-1:0] w_prod;
    logic                       r_s2_valid;
    op_e                        r_s2_op;
    logic [ACC_W-1:0]           r_s2_prod;
    logic                       r_s2_last;

    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_diff;
    logic              w_add_ovf;
    logic              w_sub_ovf;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic              w_ovf_nxt;
    logic [DATA_W-1:0] w_out_nxt;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ACC_W-1:0]  r_out_acc;

    // A held, unconsumed result freezes the whole pipe.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;

    // Stage 1: operand register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_LOAD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_last  <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            r_s1_op    <= op_e'(op);
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_last  <= last;
        end
    end

    // Stage 2: product register
    assign w_prod = r_s1_a * r_s1_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_op    <= OP_LOAD;
            r_s2_prod  <= '0;
            r_s2_last  <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            r_s2_op    <= r_s1_op;
            r_s2_prod  <= {{GUARD{w_prod[2*DATA_W-1]}}, w_prod};
            r_s2_last  <= r_s1_last;
        end
    end

    // Stage 3: accumulator with signed-overflow detection on the wrapped sum.
    assign w_sum     = r_acc + r_s2_prod;
    assign w_diff    = r_acc - r_s2_prod;
    assign w_add_ovf = (r_acc[ACC_W-1] == r_s2_prod[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_sub_ovf = (r_acc[ACC_W-1] != r_s2_prod[ACC_W-1]) &&
                       (w_diff[ACC_W-1] != r_acc[ACC_W-1]);

    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        case (r_s2_op)
            OP_LOAD: begin
                w_acc_nxt = r_s2_prod;
                w_ovf_nxt = 1'b0;
            end
            OP_MAC: begin
                w_acc_nxt = w_sum;
                w_ovf_nxt = r_ovf | w_add_ovf;
            end
            OP_MAS: begin
                w_acc_nxt = w_diff;
                w_ovf_nxt = r_ovf | w_sub_ovf;
            end
            OP_CLR: begin
                w_acc_nxt = '0;
                w_ovf_nxt = 1'b0;
            end
            default: begin
                w_acc_nxt = r_acc;
                w_ovf_nxt = r_ovf;
            end
        endcase
    end

    sat_shift #(
        .IN_W   (ACC_W),
        .OUT_W  (DATA_W),
        .SHIFT  (OUT_SHIFT),
        .SAT_EN (SAT_EN)
    ) u_sat_shift (
        .i_data (w_acc_nxt),
        .o_data (w_out_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_s2_valid && !w_stall) begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    // Output register: a new result may load in the same cycle the old one is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_acc   <= '0;
        end else if (r_s2_valid && r_s2_last && !w_stall) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_nxt;
            r_out_acc   <= w_acc_nxt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_acc   = r_out_acc;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_pipe
// Description : Directed bench for mac_pipe with saturating and truncating DUTs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_pipe;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 36;

    localparam logic [1:0] C_LOAD = 2'd0;
    localparam logic [1:0] C_MAC  = 2'd1;
    localparam logic [1:0] C_MAS  = 2'd2;
    localparam logic [1:0] C_CLR  = 2'd3;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              last;
    logic              out_ready;

    logic              in_ready,  in_ready_t;
    logic              out_valid, out_valid_t;
    logic [DATA_W-1:0] out_data,  out_data_t;
    logic [ACC_W-1:0]  out_acc,   out_acc_t;
    logic              ovf,       ovf_t;

    int checks   = 0;
    int failures = 0;

    mac_pipe #(.DATA_W(16), .GUARD(4), .OUT_SHIFT(15), .SAT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .last(last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_acc(out_acc), .ovf(ovf)
    );

    mac_pipe #(.DATA_W(16), .GUARD(4), .OUT_SHIFT(15), .SAT_EN(1'b0)) dut_trunc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
        .op(op), .a(a), .b(b), .last(last), .out_valid(out_valid_t),
        .out_ready(out_ready), .out_data(out_data_t), .out_acc(out_acc_t), .ovf(ovf_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic l);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        last     = l;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        last     = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = C_LOAD;
        a         = '0;
        b         = '0;
        last      = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state and idle
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_ovf", ovf, 1'b0);
        check("rst_out_acc", out_acc, 36'h0);
        check("rst_out_data", out_data, 16'h0);
        for (int i = 0; i < 10; i++) begin
            check("idle_out_valid", out_valid, 1'b0);
            idle();
        end

        // Single LOAD with last: latency 3
        send(C_LOAD, 16'h4000, 16'h4000, 1'b1);
        idle();
        check("lat_not_early", out_valid, 1'b0);
        idle();
        check("lat_valid", out_valid, 1'b1);
        check("lat_acc", out_acc, 36'h010000000);
        check("lat_data", out_data, 16'h2000);
        idle();
        check("lat_consumed", out_valid, 1'b0);

        // Back-to-back ops
        send(C_LOAD, 16'h4000, 16'h4000, 1'b0);
        send(C_MAC,  16'h4000, 16'h4000, 1'b1);
        send(C_MAS,  16'h4000, 16'h4000, 1'b1);
        idle();
        check("b2b_v1", out_valid, 1'b1);
        check("b2b_d1", out_data, 16'h4000);
        check("b2b_a1", out_acc, 36'h020000000);
        idle();
        check("b2b_v2", out_valid, 1'b1);
        check("b2b_d2", out_data, 16'h2000);
        idle();
        check("b2b_done", out_valid, 1'b0);

        // Saturation vs truncation
        send(C_LOAD, 16'h7FFF, 16'h7FFF, 1'b0);
        send(C_MAC,  16'h7FFF, 16'h7FFF, 1'b0);
        send(C_MAC,  16'h7FFF, 16'h7FFF, 1'b0);
        send(C_MAC,  16'h7FFF, 16'h7FFF, 1'b1);
        idle();
        idle();
        check("sat_valid", out_valid, 1'b1);
        check("sat_acc", out_acc, 36'h0FFFC0004);
        check("sat_data", out_data, 16'h7FFF);
        check("sat_ovf", ovf, 1'b0);
        check("trunc_acc", out_acc_t, 36'h0FFFC0004);
        check("trunc_data", out_data_t, 16'hFFF8);

        // Guard overflow: 32 * 2^30 wraps to -2^35
        send(C_LOAD, 16'h8000, 16'h8000, 1'b0);
        for (int i = 0; i < 30; i++) send(C_MAC, 16'h8000, 16'h8000, 1'b0);
        send(C_MAC, 16'h8000, 16'h8000, 1'b1);
        idle();
        idle();
        check("gov_valid", out_valid, 1'b1);
        check("gov_acc", out_acc, 36'h800000000);
        check("gov_ovf", ovf, 1'b1);
        check("gov_data", out_data, 16'h8000);
        check("gov_trunc_data", out_data_t, 16'h0000);
        send(C_CLR, 16'h1234, 16'h5678, 1'b0);
        idle();
        check("clr_ovf_before", ovf, 1'b1);
        idle();
        check("clr_ovf_after", ovf, 1'b0);

        // Backpressure: three results queued behind a held output
        out_ready = 1'b0;
        send(C_LOAD, 16'h4000, 16'h4000, 1'b1);
        send(C_LOAD, 16'h2000, 16'h4000, 1'b1);
        send(C_LOAD, 16'h1000, 16'h4000, 1'b1);
        idle();
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_data0", out_data, 16'h2000);
        idle();
        idle();
        check("bp_data_stable", out_data, 16'h2000);
        check("bp_acc_stable", out_acc, 36'h010000000);
        check("bp_still_stalled", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        check("bp_r2_valid", out_valid, 1'b1);
        check("bp_r2_data", out_data, 16'h1000);
        check("bp_in_ready_rel", in_ready, 1'b1);
        tick();
        check("bp_r3_valid", out_valid, 1'b1);
        check("bp_r3_data", out_data, 16'h0800);
        tick();
        check("bp_drained", out_valid, 1'b0);

        // Reset mid-stream
        send(C_LOAD, 16'h7FFF, 16'h7FFF, 1'b1);
        in_valid = 1'b0;
        last     = 1'b0;
        reset    = 1'b1;
        tick();
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_acc", out_acc, 36'h0);
        check("mrst_data", out_data, 16'h0);
        check("mrst_ovf", ovf, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_no_stale", out_valid, 1'b0);
        end
        send(C_MAC, 16'h4000, 16'h4000, 1'b1);
        idle();
        idle();
        check("mrst_mac_valid", out_valid, 1'b1);
        check("mrst_mac_acc", out_acc, 36'h010000000);
        check("mrst_mac_data", out_data, 16'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate engine; successor to the core's single-cycle T/P/accumulator datapath. Accepts one signed operand pair plus opcode per cycle over a valid/ready handshake. Stages: operand register (T-equivalent), product register (P-equivalent), accumulator. Emits a shifted, saturated result on a valid/ready output port when an op is tagged last.

Parameters:
DATA_W, 16, operand and output word width (signed two's complement)
GUARD, 4, accumulator guard bits; ACC_W = 2*DATA_W + GUARD (derived, not overridable)
OUT_SHIFT, 15, arithmetic right shift applied to accumulator before output (Q15 default)
SAT_EN, 1, 1 = saturate output to DATA_W signed range; 0 = truncate

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  op/operands present
in_ready  out  1  block accepts op this cycle
op  in  2  0=LOAD (acc=a*b), 1=MAC (acc+=a*b), 2=MAS (acc-=a*b), 3=CLR (acc=0)
a  in  DATA_W  signed operand
b  in  DATA_W  signed operand
last  in  1  emit accumulator result after this op
out_valid  out  1  result held
out_ready  in  1  consumer takes result
out_data  out  DATA_W  shifted/saturated result
out_acc  out  ACC_W  raw accumulator value captured with result
ovf  out  1  sticky accumulator overflow flag

Behaviour:
- Clock clk; reset is synchronous and active-high.
- Reset: all stage valid bits 0, acc 0, ovf 0, out_valid 0, out_data 0, out_acc 0; in_ready 1 on the first cycle after reset deasserts.
- Transfer: input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready; in_ready = !stall; all three stages hold while stall is asserted.
- Stage 1: registers op, a, b, last, and a valid bit.
- Stage 2: product = signed a*b, full 2*DATA_W bits, sign-extended to ACC_W; op, last and valid carried along.
- Stage 3 (valid, not stalled): update acc per op, wrapping at ACC_W bits.
  - ovf set on signed overflow of an add or subtract.
  - LOAD and CLR clear ovf, then apply their own result.
  - CLR ignores a and b.
- Stage 3 with last=1: out_acc <= new acc; out_data <= f(new acc); out_valid <= 1.
- Latency: op accepted in cycle N with last=1 gives out_valid=1 in cycle N+3. Throughput is one op per cycle absent stall.
- Output register: out_valid clears on consume unless a new last result loads in the same cycle. That simultaneous load-and-consume is legal, and out_valid stays 1.
- out_data computation: s = acc >>> OUT_SHIFT (arithmetic shift).
  - SAT_EN=1: if s > 2^(DATA_W-1)-1 give 0x7FFF; if s < -2^(DATA_W-1) give 0x8000; otherwise s[DATA_W-1:0].
  - SAT_EN=0: s[DATA_W-1:0].
- acc is not cleared by last; a following MAC continues the sum.
- No bubble is inserted at op boundaries.
- in_valid=0 cycles inject invalid slots, which leave acc untouched.
- Reset mid-operation drops all in-flight ops and any held result.
- Outputs are stable while out_valid && !out_ready.

Decomposition:
- Package dsp_pkg holds the op encodings (OP_LOAD, OP_MAC, OP_MAS, OP_CLR) and a width helper for ACC_W.
- One natural sub-module, sat_shift: combinational arithmetic shift plus saturation, parametrised by IN_W, OUT_W, SHIFT and SAT_EN. It is reusable by the core's accumulator output shifter.

Test Plan:
1. Reset, idle -> out_valid=0, ovf=0, in_ready=1, no output for 10 cycles.
2. LOAD a=0x4000 b=0x4000 last=1 in cycle N -> cycle N+3: out_acc=0x010000000, out_data=0x2000, out_valid=1.
3. Back-to-back ops: LOAD 0x4000*0x4000, MAC 0x4000*0x4000 last=1, MAS 0x4000*0x4000 last=1 -> two results on consecutive cycles with out_data 0x4000 then 0x2000.
4. Saturation: LOAD 0x7FFF*0x7FFF, then MAC same x3 with last on the final MAC -> out_acc=0x0FFFC0004, out_data=0x7FFF. The same with SAT_EN=0 -> out_data=0xFFF8.
5. Guard overflow: LOAD 0x8000*0x8000, then 31 MACs of the same with last on the 31st -> out_acc wraps to -2^35, ovf=1, out_data=0x8000. A following CLR clears ovf to 0.
6. Backpressure and reset: hold out_ready=0 with 3 last ops in flight -> in_ready drops, out_data stays stable, results appear in order after release. Then assert reset mid-stream -> out_valid=0, acc=0 the next cycle, no stale result.
